// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment width, blank code and active-low digit codes (a..g, a first)
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [0:SEG_W-1] SEG_BLANK = 7'b1111111;

    localparam logic [0:SEG_W-1] SEG_0 = 7'b0000001;
    localparam logic [0:SEG_W-1] SEG_1 = 7'b1001111;
    localparam logic [0:SEG_W-1] SEG_2 = 7'b0010010;
    localparam logic [0:SEG_W-1] SEG_3 = 7'b0000110;
    localparam logic [0:SEG_W-1] SEG_4 = 7'b1001100;
    localparam logic [0:SEG_W-1] SEG_5 = 7'b0100100;
    localparam logic [0:SEG_W-1] SEG_6 = 7'b1100000;
    localparam logic [0:SEG_W-1] SEG_7 = 7'b0001111;
    localparam logic [0:SEG_W-1] SEG_8 = 7'b0000000;
    localparam logic [0:SEG_W-1] SEG_9 = 7'b0001100;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD nibble to active-low segment pattern; non-BCD codes blank
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0]         bcd,
    output logic [0:SEG_W-1]   seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scanner with frame-aligned load handshake
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [0:SEG_W-1]        seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [0:SEG_W-1]        seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic                    tick;
    logic                    wrap;
    logic                    accept;
    logic [3:0]              sel_nibble;
    logic [0:SEG_W-1]        dec_seg;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        wrap    = tick && (idx_q == IDX_LAST);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        // Transfer uses the pending flag from before this edge, so a load
        // accepted on a wrap tick waits for the following wrap.
        accept     = load_valid && !pend_vld_q;
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        pend_d     = pend_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        if (wrap && pend_vld_q) begin
            disp_d     = pend_q;
            disp_dp_d  = pend_dp_q;
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            pend_d     = load_data;
            pend_dp_d  = load_dp;
            pend_vld_d = 1'b1;
        end
    end

    // Decode the digit about to be lit from the post-edge display contents.
    assign sel_nibble = disp_d[{idx_d, 2'b00} +: 4];

    seg7_decode u_decode (
        .bcd   (sel_nibble),
        .seg_n (dec_seg)
    );

    always_comb begin
        seg_d         = seg_q;
        dp_n_d        = dp_n_q;
        an_d          = an_q;
        frame_start_d = 1'b0;
        if (tick) begin
            an_d          = ~(NUM_DIGITS'(1) << idx_d);
            seg_d         = dec_seg;
            dp_n_d        = ~disp_dp_d[idx_d];
            frame_start_d = wrap;
`ifdef SEG7_LZB_EN
            if ((idx_d != '0) && !disp_dp_d[idx_d]
                && ((disp_d >> {idx_d, 2'b00}) == '0)) begin
                seg_d  = SEG_BLANK;
                dp_n_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= IDX_LAST;
            disp_q        <= '0;
            disp_dp_q     <= '0;
            pend_q        <= '0;
            pend_dp_q     <= '0;
            pend_vld_q    <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_n_q        <= 1'b1;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            disp_q        <= disp_d;
            disp_dp_q     <= disp_dp_d;
            pend_q        <= pend_d;
            pend_dp_q     <= pend_dp_d;
            pend_vld_q    <= pend_vld_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ready  = !pend_vld_q;
    assign seg         = seg_q;
    assign dp_n        = dp_n_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed and random checks of seg7_scan_driver against a time-based model
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [0:6]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_start;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_data   (load_data),
        .load_dp     (load_dp),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .seg         (seg),
        .dp_n        (dp_n),
        .an          (an),
        .frame_start (frame_start)
    );

    int errors = 0;
    int checks = 0;

    // Model: t counts edges since reset release; digit timing follows from t alone.
    int          t = 0;
    logic [15:0] m_shown = '0;
    logic [3:0]  m_sdp = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_pdp = '0;
    bit          m_pvld = 1'b0;
    bit          m_fs = 1'b0;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b1100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int lit_idx(input int tt);
        if (tt < DIV) return -1;
        return ((tt / DIV) - 1) % N;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [15:0] d, input logic [3:0] p);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dpn;
        bit         wrap;
        bit         acc;
        int         idx;
        int         msd;
        rst_n      = rst;
        load_valid = v;
        load_data  = d;
        load_dp    = p;
        @(posedge clk);
        if (!rst) begin
            t = 0; m_shown = '0; m_sdp = '0; m_pend = '0; m_pdp = '0;
            m_pvld = 1'b0; m_fs = 1'b0;
        end else begin
            t++;
            wrap = (t >= DIV) && (((t - DIV) % FRAME) == 0);
            acc  = v && !m_pvld;
            if (wrap && m_pvld) begin
                m_shown = m_pend; m_sdp = m_pdp; m_pvld = 1'b0;
            end
            if (acc) begin
                m_pend = d; m_pdp = p; m_pvld = 1'b1;
            end
            m_fs = wrap;
        end
        idx = lit_idx(t);
        if (idx < 0) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
        end else begin
            e_an  = 4'hF & ~(4'h1 << idx);
            e_seg = ref_seg(m_shown[idx*4 +: 4]);
            e_dpn = !m_sdp[idx];
`ifdef SEG7_LZB_EN
            msd = 0;
            for (int k = 0; k < N; k++) if (m_shown[k*4 +: 4] != 4'd0) msd = k;
            if (idx > msd && !m_sdp[idx]) begin
                e_seg = 7'h7F; e_dpn = 1'b1;
            end
`else
            msd = 0;
`endif
        end
        #1;
        check("an", {28'd0, an}, {28'd0, e_an});
        check("seg", {25'd0, seg}, {25'd0, e_seg});
        check("dp_n", {31'd0, dp_n}, {31'd0, e_dpn});
        check("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
        check("load_ready", {31'd0, load_ready}, {31'd0, !m_pvld});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic align_to_wrap_edge();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (((t + 1) >= DIV) && (((t + 1 - DIV) % FRAME) == 0)) return;
            idle(1);
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rp;

        // Reset and idle start-up: first digit after DIV cycles.
        step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 16'h9999, 4'hF);
        idle(20);

        // Plain load mid-frame.
        step(1'b1, 1'b1, 16'h1234, 4'b0000);
        idle(40);

        // Load mid-frame, then a second request while pending is ignored.
        idle(5);
        step(1'b1, 1'b1, 16'h5678, 4'b0000);
        step(1'b1, 1'b1, 16'h9999, 4'b1111);
        idle(40);

        // Load accepted on the wrap-tick edge waits a full frame.
        align_to_wrap_edge();
        step(1'b1, 1'b1, 16'h8765, 4'b0010);
        idle(40);

        // Leading zeros with a decimal point on digit 2.
        step(1'b1, 1'b1, 16'h0042, 4'b0100);
        idle(40);

        // Reset while digit 2 is lit with a load pending.
        align_to_wrap_edge();
        idle(1);
        step(1'b1, 1'b1, 16'h3141, 4'b1000);
        for (int i = 0; i < FRAME && lit_idx(t) != 2; i++) idle(1);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        idle(30);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            rd = 16'($urandom);
            rd = rd >> (4 * $urandom_range(0, 3));
            rp = 4'($urandom);
            if ($urandom_range(0, 1) == 0) rp = 4'h0;
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), rd, rp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
